// File: rtl/spi_host_ctrl.sv
// ---------------------------------------------------------------------------
// spi_host_ctrl
//    SPI initiator for the PSEC6 configuration/readback register port.
//    Mode 0, MSB first. A frame is one header byte {rw, addr[6:0]} followed
//    by nbytes data bytes; the target auto-increments the register address.
//
//    Ports
//       spi_clk    controller clock, all logic on posedge
//       full_rstn  asynchronous active-low reset
//       start      one-cycle frame request, only honoured in IDLE
//       rw         1 = write, 0 = read
//       addr       start register address
//       nbytes     data byte count, saturated to MAX_BYTES
//       tx_data    next write byte
//       tx_valid   tx_data valid
//       tx_ready   byte taken this cycle (tx_valid & tx_ready = transfer)
//       rx_data    last received read byte
//       rx_valid   one-cycle pulse, rx_data updated
//       busy       high from accepted start until done
//       done       one-cycle pulse at frame end
//       csb        chip select, active-low
//       sclk       serial clock, idles low
//       pico       serial data to target
//       poci       serial data from target
//
//    state   | meaning
//    --------+-------------------------------------------------------------
//    IDLE    | csb high, waiting for start
//    SETUP   | csb low, first header bit on pico, CS_SETUP cycles
//    HEADER  | shifting the 8 header bits
//    DATA    | shifting data bytes; write underrun parks here with sclk low
//    HOLD    | sclk low, csb low for CS_HOLD cycles, then done
// ---------------------------------------------------------------------------
module spi_host_ctrl #(
   parameter int CLK_DIV   = 2,
   parameter int MAX_BYTES = 16,
   parameter int CS_SETUP  = 2,
   parameter int CS_HOLD   = 2,
   parameter int BW        = $clog2(MAX_BYTES + 1)
) (
   input  logic          spi_clk,
   input  logic          full_rstn,
   input  logic          start,
   input  logic          rw,
   input  logic [6:0]    addr,
   input  logic [BW-1:0] nbytes,
   input  logic [7:0]    tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic [7:0]    rx_data,
   output logic          rx_valid,
   output logic          busy,
   output logic          done,
   output logic          csb,
   output logic          sclk,
   output logic          pico,
   input  logic          poci
);

   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CSMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CW    = (CSMAX > 1) ? $clog2(CSMAX) : 1;

   localparam logic [DW-1:0] DIV_LOAD   = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(CS_HOLD - 1);
   localparam logic [BW-1:0] MAX_NB     = BW'(MAX_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HEADER,
      ST_DATA,
      ST_HOLD
   } state_t;

   state_t        state;
   logic          rw_q;
   logic [6:0]    tx_shift;     // bits still to go out after the one on pico
   logic [7:0]    rx_shift;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [BW-1:0] byte_cnt;     // bytes left, including the one in flight
   logic [CW-1:0] cs_cnt;
   logic          wait_tx;      // write underrun: waiting for tx_valid
   logic          rx_pend;      // last rising edge of a read byte was just seen

   logic div_tc;
   logic byte_end;
   logic more_bytes;
   logic want_byte;

   assign div_tc   = (div_cnt == '0);
   assign byte_end = ((state == ST_HEADER) || (state == ST_DATA)) && !wait_tx &&
                     sclk && div_tc && (bit_cnt == 3'd0);
   // In HEADER the counter still holds the full byte count; in DATA it
   // includes the byte finishing now.
   assign more_bytes = (state == ST_HEADER) ? (byte_cnt != '0) : (byte_cnt != BW'(1));

   // The next write byte is wanted on the falling edge that closes the
   // previous byte, or at any time while parked in an underrun.
   assign want_byte = rw_q && (((state == ST_DATA) && wait_tx) || (byte_end && more_bytes));
   assign tx_ready  = want_byte && tx_valid;

   always_ff @(posedge spi_clk or negedge full_rstn) begin
      if (!full_rstn) begin
         state    <= ST_IDLE;
         rw_q     <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         cs_cnt   <= '0;
         wait_tx  <= 1'b0;
         rx_pend  <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         csb      <= 1'b1;
         sclk     <= 1'b0;
         pico     <= 1'b0;
      end else begin
         done     <= 1'b0;
         rx_valid <= 1'b0;

         if (rx_pend) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            rx_pend  <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               csb  <= 1'b1;
               sclk <= 1'b0;
               // the done cycle itself does not accept a new start
               if (start && !done) begin
                  rw_q     <= rw;
                  pico     <= rw;
                  tx_shift <= addr;
                  byte_cnt <= (nbytes > MAX_NB) ? MAX_NB : nbytes;
                  cs_cnt   <= SETUP_LOAD;
                  busy     <= 1'b1;
                  csb      <= 1'b0;
                  state    <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (cs_cnt == '0) begin
                  div_cnt <= DIV_LOAD;
                  bit_cnt <= 3'd7;
                  state   <= ST_HEADER;
               end else begin
                  cs_cnt <= cs_cnt - CW'(1);
               end
            end

            ST_HEADER, ST_DATA: begin
               if (wait_tx) begin
                  // sclk stays low and the bit timer stays loaded until data arrives
                  if (tx_valid) begin
                     pico     <= tx_data[7];
                     tx_shift <= tx_data[6:0];
                     wait_tx  <= 1'b0;
                  end
               end else if (!div_tc) begin
                  div_cnt <= div_cnt - DW'(1);
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (!sclk) begin
                     sclk     <= 1'b1;
                     rx_shift <= {rx_shift[6:0], poci};
                     if ((state == ST_DATA) && !rw_q && (bit_cnt == 3'd0)) begin
                        rx_pend <= 1'b1;
                     end
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt != 3'd0) begin
                        bit_cnt  <= bit_cnt - 3'd1;
                        pico     <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                     end else begin
                        if (state == ST_DATA) begin
                           byte_cnt <= byte_cnt - BW'(1);
                        end
                        if (!more_bytes) begin
                           pico   <= 1'b0;
                           cs_cnt <= HOLD_LOAD;
                           state  <= ST_HOLD;
                        end else begin
                           bit_cnt <= 3'd7;
                           state   <= ST_DATA;
                           if (!rw_q) begin
                              pico     <= 1'b0;
                              tx_shift <= '0;
                           end else if (tx_valid) begin
                              pico     <= tx_data[7];
                              tx_shift <= tx_data[6:0];
                           end else begin
                              wait_tx <= 1'b1;
                           end
                        end
                     end
                  end
               end
            end

            ST_HOLD: begin
               sclk <= 1'b0;
               if (cs_cnt == '0) begin
                  csb   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  cs_cnt <= cs_cnt - CW'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_host_ctrl
//    Bench for spi_host_ctrl. A target model decodes the serial lines into a
//    128-byte register array and serves read data; a write-data source feeds
//    tx_data with an optional stall. Frame expectations come from a table of
//    hand-computed vectors, from frame-length arithmetic for random frames,
//    and from the target register array.
// ---------------------------------------------------------------------------
module tb_spi_host_ctrl;

   localparam int CLK_DIV   = 2;
   localparam int MAX_BYTES = 16;
   localparam int CS_SETUP  = 2;
   localparam int CS_HOLD   = 2;
   localparam int BW        = $clog2(MAX_BYTES + 1);

   logic          spi_clk   = 1'b0;
   logic          full_rstn = 1'b0;
   logic          start     = 1'b0;
   logic          rw        = 1'b0;
   logic [6:0]    addr      = '0;
   logic [BW-1:0] nbytes    = '0;
   logic [7:0]    tx_data   = '0;
   logic          tx_valid  = 1'b0;
   logic          tx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          busy;
   logic          done;
   logic          csb;
   logic          sclk;
   logic          pico;
   logic          poci      = 1'b0;

   spi_host_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .MAX_BYTES (MAX_BYTES),
      .CS_SETUP  (CS_SETUP),
      .CS_HOLD   (CS_HOLD)
   ) dut (
      .spi_clk   (spi_clk),
      .full_rstn (full_rstn),
      .start     (start),
      .rw        (rw),
      .addr      (addr),
      .nbytes    (nbytes),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .done      (done),
      .csb       (csb),
      .sclk      (sclk),
      .pico      (pico),
      .poci      (poci)
   );

   always #5 spi_clk = ~spi_clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- target model ----------------
   logic [7:0] regs [0:127];
   logic [7:0] sh   = '0;
   logic [7:0] hdr  = '0;
   int         rises       = 0;
   int         csb_low_cnt = 0;
   int         csb_falls   = 0;
   int         low_run     = 0;
   int         max_low     = 0;
   logic       sclk_p      = 1'b0;
   logic       csb_p       = 1'b1;
   logic [7:0] wr_q [$];
   logic [7:0] rx_q [$];

   always @(negedge spi_clk) begin
      logic [7:0] cur;
      if (!csb) csb_low_cnt++;
      if (csb_p && !csb) begin
         csb_falls++;
         rises = 0;
      end
      if (!csb && !sclk_p && sclk) begin
         sh = {sh[6:0], pico};
         rises++;
         if (rises % 8 == 0) begin
            if (rises == 8) begin
               hdr = sh;
            end else if (hdr[7]) begin
               regs[(int'(hdr[6:0]) + rises / 8 - 2) % 128] = sh;
               wr_q.push_back(sh);
            end
         end
      end
      // mode 0: target updates poci while sclk is low
      if (!csb && !sclk && rises >= 8 && !hdr[7]) begin
         cur  = regs[(int'(hdr[6:0]) + (rises - 8) / 8) % 128];
         poci = cur[7 - ((rises - 8) % 8)];
      end else if (csb) begin
         poci = 1'b0;
      end
      if (!csb && !sclk) begin
         low_run++;
         if (low_run > max_low) max_low = low_run;
      end else begin
         low_run = 0;
      end
      if (rx_valid) rx_q.push_back(rx_data);
      sclk_p = sclk;
      csb_p  = csb;
   end

   // ---------------- write-data source ----------------
   logic [7:0] tx_q  [$];
   logic [7:0] pat_q [$];
   int         tx_idx     = 0;
   int         stall_idx  = -1;
   int         stall_left = 0;
   int         ready_cnt  = 0;

   initial begin
      forever begin
         @(negedge spi_clk);
         if (tx_idx == stall_idx && stall_left > 0) begin
            tx_valid = 1'b0;
            stall_left--;
         end else if (tx_idx < tx_q.size()) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[tx_idx];
         end else begin
            tx_valid = 1'b0;
         end
         #4;
         if (tx_ready) ready_cnt++;
         if (tx_valid && tx_ready) tx_idx++;
      end
   end

   // ---------------- frame helpers ----------------
   task automatic launch(input bit f_rw, input bit [6:0] f_addr, input int nb_req,
                         input int s_idx, input int s_len, output int n);
      n = (nb_req > MAX_BYTES) ? MAX_BYTES : nb_req;
      @(negedge spi_clk);
      tx_q.delete();
      for (int i = 0; i < n; i++) begin
         if (i < pat_q.size()) tx_q.push_back(pat_q[i]);
         else tx_q.push_back(8'($urandom));
      end
      if (!f_rw) begin
         for (int i = 0; i < n; i++) regs[(int'(f_addr) + i) % 128] = tx_q[i];
      end
      tx_idx      = 0;
      stall_idx   = s_idx;
      stall_left  = s_len;
      ready_cnt   = 0;
      wr_q.delete();
      rx_q.delete();
      csb_low_cnt = 0;
      csb_falls   = 0;
      max_low     = 0;
      rises       = 0;
      hdr         = '0;
      rw          = f_rw;
      addr        = f_addr;
      nbytes      = BW'(nb_req);
      start       = 1'b1;
      @(negedge spi_clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("csb_after_start", csb, 0);
   endtask

   task automatic run_frame(input string name, input bit f_rw, input bit [6:0] f_addr,
                            input int nb_req, input int s_idx, input int s_len,
                            input bit extra_start, input int exp_rises, input int exp_csb,
                            input int exp_maxlow);
      int n;
      int c;
      int dcount;
      int bad;
      launch(f_rw, f_addr, nb_req, s_idx, s_len, n);
      dcount = 0;
      c      = 0;
      while (dcount == 0 && c < 5000) begin
         @(negedge spi_clk);
         c++;
         if (done) dcount++;
         start = extra_start && (c == 20);
         if (extra_start && c == 20) addr = ~f_addr;
      end
      start = 1'b0;
      check({name, "_done_seen"}, dcount, 1);
      repeat (4) begin
         @(negedge spi_clk);
         if (done) dcount++;
      end
      check({name, "_done_count"}, dcount, 1);
      check({name, "_header"}, hdr, {f_rw, f_addr});
      check({name, "_rises"}, rises, exp_rises);
      check({name, "_csb_low"}, csb_low_cnt, exp_csb);
      check({name, "_csb_falls"}, csb_falls, 1);
      check({name, "_sclk_low_run"}, max_low, exp_maxlow);
      check({name, "_tx_ready"}, ready_cnt, f_rw ? n : 0);
      check({name, "_busy_end"}, busy, 0);
      bad = 0;
      if (f_rw) begin
         check({name, "_wr_count"}, wr_q.size(), n);
         for (int i = 0; i < n; i++) begin
            if (regs[(int'(f_addr) + i) % 128] !== tx_q[i]) bad++;
         end
         check({name, "_wr_data"}, bad, 0);
         check({name, "_rx_pulses"}, rx_q.size(), 0);
      end else begin
         check({name, "_rx_pulses"}, rx_q.size(), n);
         for (int i = 0; i < n && i < rx_q.size(); i++) begin
            if (rx_q[i] !== tx_q[i]) bad++;
         end
         check({name, "_rx_data"}, bad, 0);
         check({name, "_wr_count"}, wr_q.size(), 0);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string      name;
      bit         rw;
      logic [6:0] addr;
      int         nb;
      logic [7:0] d0;
      int         exp_rises;
      int         exp_csb;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #(1000000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c;
      int dcount;
      bit         r_rw;
      logic [6:0] r_addr;
      int         r_nb;

      // bit time is 2*CLK_DIV = 4 cycles; csb low = 2 + 4*bits + 2
      tbl[0] = '{"wr_a1",   1'b1, 7'd1,   1, 8'h3f, 16,  68};
      tbl[1] = '{"rd_a2",   1'b0, 7'd2,   1, 8'hff, 16,  68};
      tbl[2] = '{"wr_n0",   1'b1, 7'd5,   0, 8'h00,  8,  36};
      tbl[3] = '{"rd_n0",   1'b0, 7'd6,   0, 8'h00,  8,  36};
      tbl[4] = '{"wr_wrap", 1'b1, 7'h7f,  2, 8'h5a, 24, 100};
      tbl[5] = '{"rd_wrap", 1'b0, 7'h7e,  3, 8'hc3, 32, 132};

      for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);

      repeat (3) @(negedge spi_clk);
      check("rst_csb", csb, 1);
      check("rst_sclk", sclk, 0);
      check("rst_pico", pico, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      full_rstn = 1'b1;
      repeat (2) @(negedge spi_clk);

      for (int v = 0; v < 6; v++) begin
         pat_q.delete();
         for (int i = 0; i < tbl[v].nb; i++) pat_q.push_back(tbl[v].d0 + 8'(i * 37));
         run_frame(tbl[v].name, tbl[v].rw, tbl[v].addr, tbl[v].nb, -1, 0, 1'b0,
                   tbl[v].exp_rises, tbl[v].exp_csb, CS_SETUP + CLK_DIV);
         if (v == 1) check("rd_a2_rx_data_port", rx_data, 8'hff);
      end

      // write underrun of 10 cycles before the second data byte
      pat_q.delete();
      pat_q.push_back(8'h01);
      pat_q.push_back(8'ha5);
      pat_q.push_back(8'haa);
      run_frame("underrun", 1'b1, 7'd9, 3, 1, 16 * CLK_DIV - 1 + 10, 1'b0,
                32, 2 + 4 * 32 + 2 + 10, CLK_DIV + 10);
      check("underrun_reg9", regs[9], 8'h01);
      check("underrun_reg10", regs[10], 8'ha5);
      check("underrun_reg11", regs[11], 8'haa);

      // saturated byte count plus a start request while busy
      pat_q.delete();
      run_frame("max_sat", 1'b1, 7'd20, MAX_BYTES + 3, -1, 0, 1'b1,
                8 * (MAX_BYTES + 1), CS_SETUP + 16 * CLK_DIV * (MAX_BYTES + 1) + CS_HOLD,
                CS_SETUP + CLK_DIV);

      // reset in the middle of a data byte
      pat_q.delete();
      launch(1'b1, 7'd3, 2, -1, 0, n);
      c = 0;
      while (rises < 12 && c < 2000) begin
         @(negedge spi_clk);
         c++;
      end
      check("rst_mid_reached", rises, 12);
      #2;
      full_rstn = 1'b0;
      #1;
      check("rst_mid_csb", csb, 1);
      check("rst_mid_sclk", sclk, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_pico", pico, 0);
      dcount = 0;
      repeat (3) begin
         @(negedge spi_clk);
         if (done) dcount++;
      end
      full_rstn = 1'b1;
      repeat (6) begin
         @(negedge spi_clk);
         if (done) dcount++;
      end
      check("rst_mid_no_done", dcount, 0);
      check("rst_mid_idle_csb", csb, 1);

      // random frames checked against frame arithmetic and the target array
      for (int k = 0; k < 8; k++) begin
         r_rw   = 1'($urandom_range(0, 1));
         r_addr = 7'($urandom_range(0, 127));
         r_nb   = $urandom_range(0, MAX_BYTES);
         pat_q.delete();
         run_frame($sformatf("rnd%0d", k), r_rw, r_addr, r_nb, -1, 0, 1'b0,
                   8 * (1 + r_nb), CS_SETUP + 16 * CLK_DIV * (1 + r_nb) + CS_HOLD,
                   CS_SETUP + CLK_DIV);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
